// File: rtl/regression_pkg.sv
// Shared types and sizing helpers for the serial regression MAC family.
package regression_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of MUL cycles per job: one coefficient bit per clock.
    function automatic int latency(input int n_feat, input int dw);
        return n_feat * dw;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-add multiply step: conditionally adds (feat << shamt) to the
// accumulator and reports the carry out of the accumulator width.
module shift_add_step #(
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int SW = 4
) (
    input  logic [AW-1:0] acc_i,
    input  logic [DW-1:0] feat_i,
    input  logic          bit_i,
    input  logic [SW-1:0] shamt_i,
    output logic [AW-1:0] acc_o,
    output logic          carry_o
);

    logic [AW-1:0] addend;
    logic [AW:0]   sum;

    // Zero-extend the feature before shifting so no product bit is lost.
    always_comb begin
        addend = {{(AW-DW){1'b0}}, feat_i} << shamt_i;
        sum    = {1'b0, acc_i} + {1'b0, addend};
        if (bit_i) begin
            acc_o   = sum[AW-1:0];
            carry_o = sum[AW];
        end else begin
            acc_o   = acc_i;
            carry_o = 1'b0;
        end
    end

endmodule

// File: rtl/regression_serial_mac.sv
// Serial regression evaluator: y = c0 + cin + sum_k feat[k]*coef[k],
// computed with a single shift-add step per clock (N_FEAT*DW cycles/job).
module regression_serial_mac
    import regression_pkg::*;
#(
    parameter int N_FEAT = 3,
    parameter int DW     = 16,
    parameter int AW     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        c0,
    input  logic                 cin,
    input  logic [N_FEAT*DW-1:0] feat,
    input  logic [N_FEAT*DW-1:0] coef,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW-1:0]        y,
    output logic                 ovf
);

    localparam int KW = cnt_w(N_FEAT);
    localparam int IW = cnt_w(DW);

    if (AW < 2*DW) begin : g_width_check
        $error("regression_serial_mac: AW must be at least 2*DW");
    end

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [AW-1:0] y_q;
    logic          ovf_q;
    logic [AW-1:0] acc_q;
    logic          ovf_acc_q;
    logic [KW-1:0] k_q;
    logic [IW-1:0] i_q;
    logic [DW-1:0] feat_q [N_FEAT];
    logic [DW-1:0] coef_q [N_FEAT];

    logic [AW-1:0] acc_d;
    logic          carry_d;
    logic [AW:0]   load_d;

    // Intercept plus carry-in; bit AW is the carry out of the load add.
    assign load_d = {1'b0, c0} + {{AW{1'b0}}, cin};

    shift_add_step #(
        .DW (DW),
        .AW (AW),
        .SW (IW)
    ) u_step (
        .acc_i   (acc_q),
        .feat_i  (feat_q[k_q]),
        .bit_i   (coef_q[k_q][i_q]),
        .shamt_i (i_q),
        .acc_o   (acc_d),
        .carry_o (carry_d)
    );

    // Control FSM, bit/feature counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            k_q         <= '0;
            i_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        for (int k = 0; k < N_FEAT; k++) begin
                            feat_q[k] <= feat[k*DW +: DW];
                            coef_q[k] <= coef[k*DW +: DW];
                        end
                        acc_q      <= load_d[AW-1:0];
                        ovf_acc_q  <= load_d[AW];
                        k_q        <= '0;
                        i_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    acc_q     <= acc_d;
                    ovf_acc_q <= ovf_acc_q | carry_d;
                    if (i_q == IW'(DW-1)) begin
                        i_q <= '0;
                        if (k_q == KW'(N_FEAT-1)) begin
                            // Final step: publish the result with this step folded in.
                            y_q         <= acc_d;
                            ovf_q       <= ovf_acc_q | carry_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_regression_serial_mac.sv
// Self-checking bench for regression_serial_mac with a plain-arithmetic model.
module tb_regression_serial_mac;

    localparam int NF  = 3;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int LAT = NF * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     c0;
    logic              cin;
    logic [NF*DW-1:0]  feat;
    logic [NF*DW-1:0]  coef;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     y;
    logic              ovf;

    int n_checks = 0;
    int n_fail   = 0;

    regression_serial_mac #(.N_FEAT(NF), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c0        (c0),
        .cin       (cin),
        .feat      (feat),
        .coef      (coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NF*DW-1:0] pack3(input int a, input int b, input int c);
        logic [NF*DW-1:0] v;
        v = '0;
        v[0*DW +: DW] = DW'(a);
        v[1*DW +: DW] = DW'(b);
        v[2*DW +: DW] = DW'(c);
        return v;
    endfunction

    // Exact integer sum, then split into result modulo 2^AW and wrap flag.
    function automatic void model(input logic [AW-1:0] c0_v, input logic cin_v,
                                  input logic [NF*DW-1:0] f_v, input logic [NF*DW-1:0] k_v,
                                  output logic [AW-1:0] ey, output logic eo);
        longint unsigned total;
        total = 64'(c0_v) + 64'(cin_v);
        for (int k = 0; k < NF; k++)
            total = total + 64'(f_v[k*DW +: DW]) * 64'(k_v[k*DW +: DW]);
        ey = total[AW-1:0];
        eo = (total[63:AW] != 0);
    endfunction

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%0b required 1", name, in_ready);
        end
    endtask

    // Full job: accept, measure latency, check result, optional back-pressure, release.
    task automatic run_job(input string name, input logic [AW-1:0] c0_v, input logic cin_v,
                           input logic [NF*DW-1:0] f_v, input logic [NF*DW-1:0] k_v,
                           input int hold, input bit disturb);
        logic [AW-1:0] ey;
        logic          eo;
        int            cnt;
        int            busy_ready;
        model(c0_v, cin_v, f_v, k_v, ey, eo);
        wait_ready(name);
        c0 = c0_v; cin = cin_v; feat = f_v; coef = k_v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        busy_ready = 0;
        while (cnt < LAT + 20) begin
            if (disturb) begin
                in_valid = 1'($urandom_range(0, 1));
                c0   = $urandom;
                cin  = 1'($urandom_range(0, 1));
                feat = {$urandom, $urandom};
                coef = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            cnt++;
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0) busy_ready++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (cnt != LAT || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_latency: cycles=%0d out_valid=%0b required %0d and 1", name, cnt, out_valid, LAT);
        end
        n_checks++;
        if (busy_ready != 0) begin
            n_fail++;
            $display("FAIL %s_busy_ready: in_ready high %0d busy cycles required 0", name, busy_ready);
        end
        n_checks++;
        if (y !== ey) begin
            n_fail++;
            $display("FAIL %s_y: y=%h required %h", name, y, ey);
        end
        n_checks++;
        if (ovf !== eo) begin
            n_fail++;
            $display("FAIL %s_ovf: ovf=%0b required %0b", name, ovf, eo);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_checks++;
            if (y !== ey || ovf !== eo || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold%0d: y=%h ovf=%0b out_valid=%0b in_ready=%0b required %h %0b 1 0",
                         name, h, y, ovf, out_valid, in_ready, ey, eo);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        c0 = '0; cin = 1'b0; feat = '0; coef = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b y=%h ovf=%0b required 1 0 0 0",
                     in_ready, out_valid, y, ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_job("basic", 32'd10, 1'b0, pack3(2, 3, 4), pack3(5, 6, 7), 0, 1'b0);
        run_job("cin", 32'd10, 1'b1, pack3(2, 3, 4), pack3(5, 6, 7), 0, 1'b0);
    endtask

    task automatic test_overflow();
        run_job("overflow", 32'hFFFF_FFFF, 1'b0, pack3(16'hFFFF, 16'hFFFF, 16'hFFFF),
                pack3(16'hFFFF, 16'hFFFF, 16'hFFFF), 0, 1'b0);
        run_job("load_carry", 32'hFFFF_FFFF, 1'b1, pack3(0, 0, 0), pack3(1, 2, 3), 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_job("bp", 32'd10, 1'b0, pack3(2, 3, 4), pack3(5, 6, 7), 5, 1'b0);
        run_job("bp_second", 32'd123, 1'b0, pack3(9, 8, 7), pack3(0, 0, 0), 0, 1'b0);
    endtask

    task automatic test_reset_mid_job();
        run_job("pre_rst", 32'hFFFF_FFFF, 1'b0, pack3(16'hFFFF, 16'hFFFF, 16'hFFFF),
                pack3(16'hFFFF, 16'hFFFF, 16'hFFFF), 0, 1'b0);
        wait_ready("rst_mid");
        c0 = 32'hFFFF_FFFF; cin = 1'b0;
        feat = pack3(16'hFFFF, 16'hFFFF, 16'hFFFF); coef = feat; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== '0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: in_ready=%0b out_valid=%0b y=%h ovf=%0b required 1 0 0 0",
                     in_ready, out_valid, y, ovf);
        end
        run_job("after_rst", 32'd10, 1'b0, pack3(2, 3, 4), pack3(5, 6, 7), 0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        run_job("ignore_busy", 32'd10, 1'b0, pack3(2, 3, 4), pack3(5, 6, 7), 2, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [NF*DW-1:0] f_v, k_v;
            logic [AW-1:0]    c_v;
            f_v = {$urandom, $urandom};
            k_v = {$urandom, $urandom};
            c_v = (t % 2 == 0) ? $urandom : 32'(32'hFFFF_0000 | $urandom_range(0, 16'hFFFF));
            run_job($sformatf("rand%0d", t), c_v, 1'($urandom_range(0, 1)), f_v, k_v,
                    $urandom_range(0, 3), 1'(t % 3 == 0));
        end
    endtask

    task automatic test_back_to_back();
        run_job("b2b_a", 32'd0, 1'b1, pack3(1, 16'hFFFF, 16'h8000), pack3(16'hFFFF, 1, 16'h0002), 0, 1'b0);
        run_job("b2b_b", 32'd7, 1'b0, pack3(16'h1234, 16'h5678, 16'h9ABC), pack3(16'h8001, 16'h4002, 16'h2004), 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid_job();
        test_ignore_busy();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
